// File: rtl/square_motion_ctrl_if.sv
// Byte-stream handshake from the UART receiver into the square motion controller.
interface square_motion_ctrl_if;
  logic       rx_wr;
  logic [7:0] rx_data;

  modport master (output rx_wr, output rx_data);
  modport slave  (input  rx_wr, input  rx_data);
endinterface

// File: rtl/square_motion_ctrl.sv
// Keyboard-driven square mover: parses single keys and ANSI arrow sequences, steps the square per tick.
// Define SQUARE_WRAP_EN to wrap at screen edges instead of clamping and stopping.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for a command byte or an ESC
// ST_ESC   | ESC received, expecting '[' (timer running)
// ST_CSI   | ESC '[' received, expecting A/B/C/D (timer running)
module square_motion_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SQUARE_SIZE = 18,
  parameter int TICK_DIV    = 310000,
  parameter int HOLE_X      = 300,
  parameter int HOLE_Y      = 198,
  parameter int HOLE_SIZE   = 20,
  parameter int INIT_X      = 0,
  parameter int INIT_Y      = 200,
  parameter int ESC_TIMEOUT = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  square_motion_ctrl_if.slave  i_rx,
  output logic [9:0]           o_pos_x,
  output logic [9:0]           o_pos_y,
  output logic [2:0]           o_dir,
  output logic                 o_win,
  output logic [7:0]           o_last_byte,
  output logic                 o_move_tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = $clog2(ESC_TIMEOUT + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [EW-1:0] ESC_LAST  = EW'(ESC_TIMEOUT);
  localparam logic [10:0]   X_MAX     = 11'(H_RES - SQUARE_SIZE);
  localparam logic [10:0]   Y_MAX     = 11'(V_RES - SQUARE_SIZE);
  localparam logic [9:0]    X_INIT    = 10'(INIT_X);
  localparam logic [9:0]    Y_INIT    = 10'(INIT_Y);

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_UP    = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_ESC, ST_CSI} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_wr_d;
  logic [TW-1:0]   r_tick_cnt;
  logic [EW-1:0]   r_esc_tmr;
  logic [9:0]      r_pos_x, r_pos_y;
  logic [2:0]      r_dir;
  logic            r_win;
  logic [7:0]      r_last_byte;
  logic            r_move_tick;

  logic            w_accept, w_wrap, w_esc_timeout;
  logic            w_plain, w_cmd_valid, w_restart;
  logic [2:0]      w_cmd_dir;
  logic [10:0]     w_x_inc, w_x_dec, w_y_inc, w_y_dec;
  logic [9:0]      w_x_nxt, w_y_nxt;
  logic            w_stop;
  logic [10:0]     w_x_end, w_y_end;
  logic            w_in_hole;

  // Rising-edge detect; r_wr_d resets high so a level held through reset is ignored.
  assign w_accept      = i_rx.rx_wr & ~r_wr_d;
  assign w_wrap        = (r_tick_cnt == TICK_LAST);
  assign w_esc_timeout = (r_state != ST_IDLE) && (r_esc_tmr == ESC_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_plain     = 1'b0;
    w_cmd_valid = 1'b0;
    w_cmd_dir   = DIR_STOP;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_plain = 1'b1;
      ST_ESC: begin
        if (w_accept) begin
          if (i_rx.rx_data == 8'h5B) w_state_nxt = ST_CSI;
          else begin
            w_state_nxt = ST_IDLE;
            w_plain     = 1'b1;
          end
        end else if (w_esc_timeout) w_state_nxt = ST_IDLE;
      end
      ST_CSI: begin
        if (w_accept) begin
          w_state_nxt = ST_IDLE;
          case (i_rx.rx_data)
            8'h41: begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_UP;    end
            8'h42: begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_DOWN;  end
            8'h43: begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_RIGHT; end
            8'h44: begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_LEFT;  end
            default: ;
          endcase
        end else if (w_esc_timeout) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_plain) begin
      case (i_rx.rx_data)
        8'h1B:        w_state_nxt = ST_ESC;
        8'h64, 8'h43: begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_RIGHT; end
        8'h61, 8'h44: begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_LEFT;  end
        8'h77, 8'h41: begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_UP;    end
        8'h73, 8'h42: begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_DOWN;  end
        8'h20:        begin w_cmd_valid = 1'b1; w_cmd_dir = DIR_STOP;  end
        8'h72:        w_restart = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                                         r_esc_tmr <= '0;
    else if (w_accept || r_state == ST_IDLE || w_esc_timeout) r_esc_tmr <= '0;
    else                                               r_esc_tmr <= r_esc_tmr + 1'b1;
  end

  // Steps are computed 11 bits wide so a decrement below zero shows up in bit 10.
  always_comb begin
    w_x_inc = {1'b0, r_pos_x} + 11'd1;
    w_x_dec = {1'b0, r_pos_x} - 11'd1;
    w_y_inc = {1'b0, r_pos_y} + 11'd1;
    w_y_dec = {1'b0, r_pos_y} - 11'd1;
    w_x_nxt = r_pos_x;
    w_y_nxt = r_pos_y;
    w_stop  = 1'b0;
    case (r_dir)
      DIR_RIGHT:
        if (w_x_inc > X_MAX) begin
`ifdef SQUARE_WRAP_EN
          w_x_nxt = 10'd0;
`else
          w_stop  = 1'b1;
`endif
        end else w_x_nxt = w_x_inc[9:0];
      DIR_LEFT:
        if (w_x_dec[10]) begin
`ifdef SQUARE_WRAP_EN
          w_x_nxt = X_MAX[9:0];
`else
          w_stop  = 1'b1;
`endif
        end else w_x_nxt = w_x_dec[9:0];
      DIR_DOWN:
        if (w_y_inc > Y_MAX) begin
`ifdef SQUARE_WRAP_EN
          w_y_nxt = 10'd0;
`else
          w_stop  = 1'b1;
`endif
        end else w_y_nxt = w_y_inc[9:0];
      DIR_UP:
        if (w_y_dec[10]) begin
`ifdef SQUARE_WRAP_EN
          w_y_nxt = Y_MAX[9:0];
`else
          w_stop  = 1'b1;
`endif
        end else w_y_nxt = w_y_dec[9:0];
      default: ;
    endcase
  end

  assign w_x_end   = {1'b0, r_pos_x} + 11'(SQUARE_SIZE);
  assign w_y_end   = {1'b0, r_pos_y} + 11'(SQUARE_SIZE);
  assign w_in_hole = ({1'b0, r_pos_x} >= 11'(HOLE_X)) && (w_x_end <= 11'(HOLE_X + HOLE_SIZE)) &&
                     ({1'b0, r_pos_y} >= 11'(HOLE_Y)) && (w_y_end <= 11'(HOLE_Y + HOLE_SIZE));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_d      <= 1'b1;
      r_tick_cnt  <= '0;
      r_pos_x     <= X_INIT;
      r_pos_y     <= Y_INIT;
      r_dir       <= DIR_STOP;
      r_win       <= 1'b0;
      r_last_byte <= 8'h00;
      r_move_tick <= 1'b0;
    end else begin
      r_wr_d      <= i_rx.rx_wr;
      r_move_tick <= w_wrap & ~w_restart;
      if (w_accept) r_last_byte <= i_rx.rx_data;
      if (w_restart) begin
        r_tick_cnt <= '0;
        r_pos_x    <= X_INIT;
        r_pos_y    <= Y_INIT;
        r_dir      <= DIR_STOP;
        r_win      <= 1'b0;
      end else begin
        r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + 1'b1;
        // Once in the hole the square is frozen until restart.
        if (r_win || w_in_hole) begin
          r_win <= 1'b1;
          r_dir <= DIR_STOP;
        end else begin
          if (w_wrap) begin
            r_pos_x <= w_x_nxt;
            r_pos_y <= w_y_nxt;
            if (w_stop) r_dir <= DIR_STOP;
          end
          if (w_cmd_valid) r_dir <= w_cmd_dir;
        end
      end
    end
  end

  assign o_pos_x     = r_pos_x;
  assign o_pos_y     = r_pos_y;
  assign o_dir       = r_dir;
  assign o_win       = r_win;
  assign o_last_byte = r_last_byte;
  assign o_move_tick = r_move_tick;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed bench for square_motion_ctrl with a queue of expected per-tick positions.
module tb_square_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pos_x, pos_y;
  logic [2:0] dir;
  logic       win;
  logic [7:0] last_byte;
  logic       move_tick;

  square_motion_ctrl_if rx_if ();

  square_motion_ctrl #(.TICK_DIV(4), .ESC_TIMEOUT(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx_if.slave),
    .o_pos_x     (pos_x),
    .o_pos_y     (pos_y),
    .o_dir       (dir),
    .o_win       (win),
    .o_last_byte (last_byte),
    .o_move_tick (move_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    d;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   all_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_if.rx_wr   = 1'b1;
    rx_if.rx_data = b;
    @(negedge clk);
    rx_if.rx_wr   = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (move_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic push_exp(input string tag, input int x, input int y, input int d);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.d = d;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    bit   ok;
    wait_tick(ok);
    e = q.pop_front();
    chk({e.tag, "_tick_seen"}, 32'(ok), 32'd1);
    chk({e.tag, "_x"}, 32'(pos_x), 32'(e.x));
    chk({e.tag, "_y"}, 32'(pos_y), 32'(e.y));
    chk({e.tag, "_dir"}, 32'(dir), 32'(e.d));
  endtask

  task automatic skip_ticks(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_tick(ok);
      all_ok &= ok;
    end
  endtask

  initial begin
    rst           = 1'b1;
    rx_if.rx_wr   = 1'b0;
    rx_if.rx_data = 8'h00;
    all_ok        = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pos_x", 32'(pos_x), 32'd0);
    chk("rst_pos_y", 32'(pos_y), 32'd200);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    chk("rst_last", 32'(last_byte), 32'd0);
    chk("rst_tick", 32'(move_tick), 32'd0);
    rst = 1'b0;

    // 'd' then four steps right
    send_byte(8'h64);
    chk("d_dir", 32'(dir), 32'd1);
    chk("d_last", 32'(last_byte), 32'h64);
    for (int i = 1; i <= 4; i++) push_exp("right", i, 200, 1);
    repeat (4) pop_check();

    // ANSI up arrow
    send_byte(8'h72);
    chk("r1_x", 32'(pos_x), 32'd0);
    chk("r1_y", 32'(pos_y), 32'd200);
    chk("r1_dir", 32'(dir), 32'd0);
    send_byte(8'h1B);
    send_byte(8'h5B);
    send_byte(8'h41);
    chk("csi_up_dir", 32'(dir), 32'd3);
    chk("csi_up_last", 32'(last_byte), 32'h41);
    push_exp("up", 0, 199, 3);
    push_exp("up", 0, 198, 3);
    repeat (2) pop_check();
    send_byte(8'h64);
    chk("csi_idle_after", 32'(dir), 32'd1);

    // left at x = 0
    send_byte(8'h72);
    send_byte(8'h61);
    chk("a_dir", 32'(dir), 32'd2);
`ifdef SQUARE_WRAP_EN
    push_exp("left_edge", 622, 200, 2);
`else
    push_exp("left_edge", 0, 200, 0);
`endif
    pop_check();

    // up to the top edge
    send_byte(8'h72);
    send_byte(8'h77);
    skip_ticks(199);
    push_exp("top", 0, 0, 3);
`ifdef SQUARE_WRAP_EN
    push_exp("top_edge", 0, 462, 3);
`else
    push_exp("top_edge", 0, 0, 0);
`endif
    repeat (2) pop_check();

    // drive right into the hole
    send_byte(8'h72);
    send_byte(8'h64);
    skip_ticks(299);
    push_exp("hole", 300, 200, 1);
    pop_check();
    chk("win_not_yet", 32'(win), 32'd0);
    @(negedge clk);
    chk("win_set", 32'(win), 32'd1);
    chk("win_dir", 32'(dir), 32'd0);
    send_byte(8'h64);
    chk("win_ignore_dir", 32'(dir), 32'd0);
    push_exp("frozen", 300, 200, 0);
    push_exp("frozen", 300, 200, 0);
    repeat (2) pop_check();
    chk("win_sticky", 32'(win), 32'd1);
    send_byte(8'h72);
    chk("restart_x", 32'(pos_x), 32'd0);
    chk("restart_y", 32'(pos_y), 32'd200);
    chk("restart_win", 32'(win), 32'd0);
    chk("restart_dir", 32'(dir), 32'd0);

    // escape timeout: plain 'C'
    send_byte(8'h1B);
    repeat (20) @(negedge clk);
    send_byte(8'h43);
    chk("timeout_C", 32'(dir), 32'd1);
    send_byte(8'h72);
    // after timeout '[' is a no-op, so the following 'd' is a plain command
    send_byte(8'h1B);
    repeat (20) @(negedge clk);
    send_byte(8'h5B);
    send_byte(8'h64);
    chk("timeout_bracket", 32'(dir), 32'd1);
    send_byte(8'h72);
    send_byte(8'h1B);
    send_byte(8'h78);
    chk("esc_x_dir", 32'(dir), 32'd0);
    chk("esc_x_last", 32'(last_byte), 32'h78);
    send_byte(8'h64);
    chk("esc_x_idle", 32'(dir), 32'd1);

    // rx_wr held high for 10 cycles while in CSI: one accept only
    send_byte(8'h72);
    send_byte(8'h1B);
    send_byte(8'h5B);
    @(negedge clk);
    rx_if.rx_wr   = 1'b1;
    rx_if.rx_data = 8'h64;
    repeat (10) @(negedge clk);
    rx_if.rx_wr   = 1'b0;
    @(negedge clk);
    chk("held_dir", 32'(dir), 32'd0);
    chk("held_last", 32'(last_byte), 32'h64);

    // rx_wr high through reset release
    rx_if.rx_wr   = 1'b1;
    rx_if.rx_data = 8'h64;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rx_if.rx_wr = 1'b0;
    @(negedge clk);
    chk("rst_held_dir", 32'(dir), 32'd0);
    chk("rst_held_last", 32'(last_byte), 32'd0);

    chk("all_ticks_seen", 32'(all_ok), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
